// File: rtl/mult_acc_fixed_if.sv
// Stream bundle for mult_acc_fixed: input beats (feature, weight, last) and
// the rescaled group result, each under its own valid/ready pair.
interface mult_acc_fixed_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mult_acc_fixed.sv
// Pipelined fixed-point MAC: unsigned feature x signed weight, summed over a
// group closed by in_last, then rescaled, rounded and saturated to OUT_W.
//
// state    | meaning
// GRP_IDLE | next stage-2 beat starts a new group (acc is reloaded)
// GRP_OPEN | a group is in progress; stage-2 beats add into acc
module mult_acc_fixed #(
    parameter int A_W      = 8,
    parameter int A_FRAC   = 7,
    parameter int B_W      = 8,
    parameter int B_FRAC   = 6,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 5,
    parameter int ACC_W    = 24,
    parameter int ROUND    = 0
) (
    input logic              clk,
    input logic              rst,
    mult_acc_fixed_if.slave  bus
);
    localparam int P_W = A_W + B_W + 1;
    localparam int SH  = A_FRAC + B_FRAC - OUT_FRAC;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   OUT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   RND_ADD = (ROUND != 0) ? ((ACC_W+1)'(1) << (SH-1)) : '0;

    typedef enum logic {GRP_IDLE, GRP_OPEN} grp_state_t;

    grp_state_t grp_state, grp_next;

    logic                    en;
    logic                    accept;
    logic signed [P_W-1:0]   a_ext, b_ext, prod;

    logic                    v1;
    logic                    last1;
    logic signed [P_W-1:0]   p1;

    logic signed [ACC_W-1:0] acc;
    logic                    acc_sat;
    logic signed [ACC_W-1:0] acc_base;
    logic                    sat_base;
    logic signed [ACC_W:0]   acc_sum;
    logic                    acc_ovf;
    logic signed [ACC_W-1:0] acc_next;
    logic                    acc_sat_next;

    logic signed [ACC_W:0]   s_wide;
    logic signed [ACC_W:0]   r;
    logic [OUT_W-1:0]        r_clamped;
    logic                    clamp_hit;

    logic                    out_valid_r;
    logic [OUT_W-1:0]        out_data_r;
    logic                    out_sat_r;

    // A stalled output freezes the entire pipe, so in_ready tracks out_ready.
    assign en           = !(out_valid_r && !bus.out_ready);
    assign accept       = bus.in_valid && en;
    assign bus.in_ready = en;

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;

    // Both operands extended to P_W so the signed product is exact.
    assign a_ext = signed'({{(B_W+1){1'b0}}, bus.in_a});
    assign b_ext = signed'({{(A_W+1){bus.in_b[B_W-1]}}, bus.in_b});
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            p1    <= '0;
        end else if (en) begin
            v1 <= accept;
            if (accept) begin
                p1    <= prod;
                last1 <= bus.in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_state <= GRP_IDLE;
        end else begin
            grp_state <= grp_next;
        end
    end

    always_comb begin
        grp_next = grp_state;
        if (en && v1) begin
            grp_next = last1 ? GRP_IDLE : GRP_OPEN;
        end
    end

    // Accumulate one bit wider, then clamp back to ACC_W on overflow.
    always_comb begin
        acc_base     = (grp_state == GRP_OPEN) ? acc : '0;
        sat_base     = (grp_state == GRP_OPEN) && acc_sat;
        acc_sum      = signed'({acc_base[ACC_W-1], acc_base})
                     + signed'({{(ACC_W+1-P_W){p1[P_W-1]}}, p1});
        acc_ovf      = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
        acc_next     = acc_sum[ACC_W-1:0];
        if (acc_ovf) begin
            acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        acc_sat_next = sat_base | acc_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (en && v1) begin
            acc     <= acc_next;
            acc_sat <= acc_sat_next;
        end
    end

    // Rescale in ACC_W+1 bits so the rounding offset cannot wrap.
    always_comb begin
        s_wide    = signed'({acc_next[ACC_W-1], acc_next}) + RND_ADD;
        r         = s_wide >>> SH;
        clamp_hit = 1'b0;
        r_clamped = r[OUT_W-1:0];
        if (r > OUT_MAX) begin
            clamp_hit = 1'b1;
            r_clamped = OUT_MAX[OUT_W-1:0];
        end else if (r < OUT_MIN) begin
            clamp_hit = 1'b1;
            r_clamped = OUT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else if (en) begin
            if (v1 && last1) begin
                out_valid_r <= 1'b1;
                out_data_r  <= r_clamped;
                out_sat_r   <= acc_sat_next | clamp_hit;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_acc_fixed.sv
// Directed bench for mult_acc_fixed: three instances (truncate, round,
// 17-bit accumulator) driven with identical beats and checked against hand values.
module tb_mult_acc_fixed;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int last_acc = 0;
    int last_wait = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    int         qcyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_acc_fixed_if u_if0 ();
    mult_acc_fixed_if u_if1 ();
    mult_acc_fixed_if u_if2 ();

    assign u_if0.in_valid = in_valid;
    assign u_if0.in_a = in_a;
    assign u_if0.in_b = in_b;
    assign u_if0.in_last = in_last;
    assign u_if0.out_ready = out_ready;
    assign u_if1.in_valid = in_valid;
    assign u_if1.in_a = in_a;
    assign u_if1.in_b = in_b;
    assign u_if1.in_last = in_last;
    assign u_if1.out_ready = out_ready;
    assign u_if2.in_valid = in_valid;
    assign u_if2.in_a = in_a;
    assign u_if2.in_b = in_b;
    assign u_if2.in_last = in_last;
    assign u_if2.out_ready = out_ready;

    mult_acc_fixed #(.ROUND(0)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));
    mult_acc_fixed #(.ROUND(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
    mult_acc_fixed #(.ACC_W(17)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));

    // Handshakes are sampled mid low-phase; they complete on the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (u_if0.out_valid && u_if0.out_ready) begin
                q0.push_back({u_if0.out_sat, u_if0.out_data});
                qcyc.push_back(cyc + 1);
            end
            if (u_if1.out_valid && u_if1.out_ready) q1.push_back({u_if1.out_sat, u_if1.out_data});
            if (u_if2.out_valid && u_if2.out_ready) q2.push_back({u_if2.out_sat, u_if2.out_data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        #2;
        while (!u_if0.in_ready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        last_wait = n;
        last_acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_results(input string tag, input int n);
        int k = 0;
        while ((q0.size() < n || q1.size() < n || q2.size() < n) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(q0.size() >= n && q1.size() >= n && q2.size() >= n), 32'd1);
    endtask

    task automatic pop_res(output logic [8:0] r0, output logic [8:0] r1,
                           output logic [8:0] r2, output int c);
        r0 = (q0.size() > 0) ? q0.pop_front() : 9'h1FF;
        r1 = (q1.size() > 0) ? q1.pop_front() : 9'h1FF;
        r2 = (q2.size() > 0) ? q2.pop_front() : 9'h1FF;
        c  = (qcyc.size() > 0) ? qcyc.pop_front() : -1;
    endtask

    initial begin
        logic [8:0] r0, r1, r2, s0, s1, s2;
        int c, cb, t0, n;

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(u_if0.out_valid), 32'd0);
        check("rst_data", 32'(u_if0.out_data), 32'd0);
        check("rst_sat", 32'(u_if0.out_sat), 32'd0);
        check("rst_in_ready", 32'(u_if0.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1.0 x 1.0 -> 1.0 in Q2.5
        send_beat(8'h80, 8'h40, 1'b1);
        t0 = last_acc;
        check("t1_in_ready", 32'(last_wait), 32'd0);
        wait_results("t1_count", 1);
        pop_res(r0, r1, r2, c);
        check("t1_result", 32'(r0), {23'd0, 1'b0, 8'h20});
        check("t1_latency", 32'(c - t0), 32'd2);

        // -127.5: floor vs round-half-up
        send_beat(8'hFF, 8'h80, 1'b1);
        wait_results("t2_count", 1);
        pop_res(r0, r1, r2, c);
        check("t2_trunc", 32'(r0), {23'd0, 1'b0, 8'h80});
        check("t2_round", 32'(r1), {23'd0, 1'b0, 8'h81});

        // sum 64770 saturates, then a clean group with no bubble
        send_beat(8'hFF, 8'h7F, 1'b0);
        send_beat(8'hFF, 8'h7F, 1'b1);
        send_beat(8'h80, 8'h40, 1'b1);
        wait_results("t3_count", 2);
        pop_res(r0, r1, r2, c);
        pop_res(s0, s1, s2, cb);
        check("t3_sat_res", 32'(r0), {23'd0, 1'b1, 8'h7F});
        check("t3_sat_acc17", 32'(r2), {23'd0, 1'b1, 8'h7F});
        check("t3_next_res", 32'(s0), {23'd0, 1'b0, 8'h20});
        check("t3_no_bubble", 32'(cb - c), 32'd1);

        // six single-beat groups with a 3-cycle output stall after the first result
        t0 = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send_beat(8'(8'h80 >> k), 8'h40, 1'b1);
                    if (k == 0) t0 = last_acc;
                end
            end
            begin
                n = 0;
                while (!u_if0.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("t4_first_valid", 32'(u_if0.out_valid), 32'd1);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("t4_stall_in_ready", 32'(u_if0.in_ready), 32'd0);
                    check("t4_stall_hold", 32'(u_if0.out_data), 32'h20);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        wait_results("t4_count", 6);
        for (int k = 0; k < 6; k++) begin
            pop_res(r0, r1, r2, c);
            check("t4_data", 32'(r0), {23'd0, 1'b0, 8'(8'h20 >> k)});
            check("t4_delay", 32'(c - t0), 32'(5 + k));
        end

        // three max beats: 17-bit accumulator clamps at 65535
        repeat (2) send_beat(8'hFF, 8'h7F, 1'b0);
        send_beat(8'hFF, 8'h7F, 1'b1);
        wait_results("t5_count", 1);
        pop_res(r0, r1, r2, c);
        check("t5_acc17_res", 32'(r2), {23'd0, 1'b1, 8'h7F});
        check("t5_acc24_res", 32'(r0), {23'd0, 1'b1, 8'h7F});
        check("t5_acc17_clamp", 32'(unsigned'(u_dut2.acc)), 32'd65535);

        // clamp then pull back down: 97155-65280 = 31875 unclamped, 255 clamped
        repeat (3) send_beat(8'hFF, 8'h7F, 1'b0);
        send_beat(8'hFF, 8'h80, 1'b0);
        send_beat(8'hFF, 8'h80, 1'b1);
        wait_results("t5b_count", 1);
        pop_res(r0, r1, r2, c);
        check("t5b_acc24_trunc", 32'(r0), {23'd0, 1'b0, 8'h7C});
        check("t5b_acc24_round", 32'(r1), {23'd0, 1'b0, 8'h7D});
        check("t5b_acc17_sticky", 32'(r2), {23'd0, 1'b1, 8'h00});

        // reset in the middle of a group
        send_beat(8'hFF, 8'h7F, 1'b0);
        send_beat(8'hFF, 8'h7F, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(u_if0.out_valid), 32'd0);
        check("t6_rst_data", 32'(u_if0.out_data), 32'd0);
        check("t6_rst_sat17", 32'(u_if2.out_sat), 32'd0);
        check("t6_rst_in_ready", 32'(u_if0.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_beat(8'h80, 8'h40, 1'b1);
        wait_results("t6_count", 1);
        pop_res(r0, r1, r2, c);
        check("t6_result", 32'(r0), {23'd0, 1'b0, 8'h20});
        check("t6_result_acc17", 32'(r2), {23'd0, 1'b0, 8'h20});

        repeat (5) @(negedge clk);
        check("no_extra_results", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_acc_fixed.md
# mult_acc_fixed

Pipelined, parametrised fixed-point multiply-accumulate unit for the datapath's feature×weight products. It multiplies an unsigned feature by a signed weight and sums the products over a group of beats delimited by `in_last`. It then rescales, rounds and saturates the sum to the output format under valid/ready flow control. A group of length 1 is a plain registered multiply, bit-exact with the existing single-cycle multiplier when `ROUND=0` and the parameters are left at their defaults.

## Interface
- `A_W`, 8: feature width, unsigned.
- `A_FRAC`, 7: feature fractional bits.
- `B_W`, 8: weight width, two's complement.
- `B_FRAC`, 6: weight fractional bits.
- `OUT_W`, 8: result width, two's complement.
- `OUT_FRAC`, 5: result fractional bits. Must satisfy `A_FRAC+B_FRAC >= OUT_FRAC+1`.
- `ACC_W`, 24: accumulator width, signed. Must satisfy `ACC_W >= A_W+B_W+1`.
- `ROUND`, 0: selects the rescale mode. 0 = truncate (floor). 1 = round half up.
- `clk` in 1: the only clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: the block accepts the beat in any cycle where `in_valid && in_ready`.
- `in_a` in `A_W`: unsigned feature.
- `in_b` in `B_W`: signed weight.
- `in_last` in 1: marks the final beat of a group.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out `OUT_W`: rounded, saturated group sum.
- `out_sat` out 1: saturation occurred somewhere in this group's result.

## Operation
**Global enable.** `en = !(out_valid && !out_ready)`. `in_ready = en`; this is a combinational path from `out_ready`. When `en=0`, every register holds its value.

**Stage 1 (multiply).** On an accepted beat:
- P = zero-extend(`in_a`) × sign-extend(`in_b`), computed signed at width `A_W+B_W+1`, with `A_FRAC+B_FRAC` fractional bits. P is exact.
- Register P, `in_last` and `v1=1`.
- When `en=1` and no beat is accepted, `v1` becomes 0.

**Stage 2 (accumulate).** Acts when `en && v1`:
- `grp_open` = 0 means the next beat starts a new group. In that case `acc <= sext(P)` and `acc_sat <= 0`.
- Otherwise `acc <= acc + sext(P)`.
- If the sum overflows `ACC_W`, `acc` clamps to the signed `ACC_W` maximum or minimum, and `acc_sat <= 1` (sticky for the rest of the group).
- `grp_open <= !last1`.

**Rescale.** When the stage-2 beat has `last1=1`, the final accumulated value S (including this beat) is rescaled in the same cycle:
- SH = `A_FRAC+B_FRAC-OUT_FRAC`.
- `ROUND=0`: R = S >>> SH (arithmetic shift, i.e. floor).
- `ROUND=1`: R = (S + 2^(SH-1)) >>> SH, computed one bit wider so the addition cannot wrap.
- R is clamped to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Register `out_data <= clamped R`.
- Register `out_sat <= acc_sat_next | clamp_hit`, where `acc_sat_next` includes any accumulator overflow on this final beat.
- Set `out_valid <= 1`.

**Output register.**
- When `en=1` and no last beat arrives, `out_valid <= 0`.
- `out_data` and `out_sat` hold their last values while `out_valid=0`.

**Boundary cases.**
- Back-to-back groups: a last beat followed by a new group's first beat in the next cycle is legal and needs no bubble.
- A stall in the middle of a group freezes both `acc` and `v1`; no beat is lost or duplicated.
- `in_last` has no effect on a cycle where the beat is not accepted.

**Reset** (asynchronous, at any time, including mid-group or mid-stall) forces:
- `v1=0`, `out_valid=0`, `grp_open=0`, `acc=0`, `acc_sat=0`, `out_data=0`, `out_sat=0`.
- `in_ready=1` (follows from `out_valid=0`).
- Any partial group is discarded.

## Timing
- Latency: a last beat accepted at cycle t gives `out_valid=1` at cycle t+2, provided there are no stalls.
- Throughput: one beat per cycle while `out_ready=1`.
- Each cycle with `out_valid && !out_ready` adds exactly one cycle of latency to every in-flight beat.
- `out_data` and `out_sat` stay stable while `out_valid && !out_ready`.
- No combinational path from `in_*` to `out_*`. The only combinational input-to-output path is `out_ready`→`in_ready`.

## Test plan
All scenarios use default parameters unless a `ROUND` value is given.

1. **Unity multiply.** Apply `rst`, release it. Send one beat A=0x80, B=0x40, last=1, with `out_ready=1`.
   -> `out_valid` at t+2, `out_data`=0x20, `out_sat`=0. `in_ready` stays 1 throughout.
2. **Rounding mode.** A=0xFF, B=0x80, last=1, exact value -127.5.
   -> `ROUND=0`: `out_data`=0x80. `ROUND=1`: `out_data`=0x81. Both give `out_sat`=0.
3. **Output saturation.** Send two beats of A=0xFF, B=0x7F, the second with last=1 (sum 64770).
   -> `out_data`=0x7F, `out_sat`=1.
   - Follow immediately with a one-beat group A=0x80, B=0x40, last=1.
   - -> next result is `out_data`=0x20, `out_sat`=0, with no bubble between the two results.
4. **Backpressure.** Stream 6 single-beat groups with B=0x40 and A = 0x80, 0x40, … while holding `out_ready=0` for 3 cycles after the first result.
   -> `in_ready`=0 during the stall, `out_data` is held, all 6 results arrive in order with none lost or duplicated, and each is delayed by 3 cycles.
5. **Accumulator overflow.** Use `ACC_W=17`. Send three beats of A=0xFF, B=0x7F, last on the third.
   -> the accumulator clamps at 65535, `out_data`=0x7F, `out_sat`=1.
6. **Reset mid-group.** Accept 2 non-last beats, assert `rst` asynchronously between clock edges, release it, then send A=0x80, B=0x40, last=1.
   -> all outputs are 0 during reset, and the result is exactly 0x20 with no residue from the discarded partial group.
